// File: rtl/spi_slave_frame.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_frame
// Brief    : SPI mode-0 slave, oversampled in clk domain; decodes a
//            cmd/addr/data frame and serves read data on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_frame #(
    parameter int              CMD_W       = 8,
    parameter int              ADDR_W      = 24,
    parameter int              DATA_W      = 32,
    parameter logic [CMD_W-1:0] CMD_READ   = 8'h03,
    parameter int              SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] rd_data,
    output logic [CMD_W-1:0]  cmd_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic              frame_valid,
    output logic              frame_err
);

    localparam int         c_AC_MAX    = (ADDR_W > CMD_W) ? ADDR_W : CMD_W;
    localparam int         c_SH_W      = (DATA_W > c_AC_MAX) ? DATA_W : c_AC_MAX;
    localparam logic [6:0] c_CMD_LAST  = 7'(CMD_W - 1);
    localparam logic [6:0] c_ADDR_LAST = 7'(ADDR_W - 1);
    localparam logic [6:0] c_DATA_LAST = 7'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_RDLOAD = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_WAITCS = 3'd6
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_cs_sync;
    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_cs_prev;
    logic                    r_sclk_prev;
    logic [6:0]              r_cnt;
    logic [c_SH_W-1:0]       r_shift;
    logic [DATA_W-1:0]       r_tx;
    logic                    r_rd_req_d;

    logic                    w_cs;
    logic                    w_sclk;
    logic                    w_mosi;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_cs_fall;
    logic                    w_cs_rise;
    logic [c_SH_W-1:0]       w_shift_next;
    logic [DATA_W-1:0]       w_tx_src;

    assign w_cs         = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise       = w_sclk & ~r_sclk_prev;
    assign w_fall       = ~w_sclk & r_sclk_prev;
    assign w_cs_fall    = ~w_cs & r_cs_prev;
    assign w_cs_rise    = w_cs & ~r_cs_prev;
    assign w_shift_next = {r_shift[c_SH_W-2:0], w_mosi};
    // A fast SCLK can put the first data fall on the same cycle rd_data is latched.
    assign w_tx_src     = (r_state == S_RDLOAD && r_rd_req_d) ? rd_data : r_tx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_rd_req_d  <= 1'b0;
            cmd_out     <= '0;
            addr_out    <= '0;
            wr_data     <= '0;
            MISO        <= 1'b0;
            rd_req      <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rd_req      <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            r_rd_req_d  <= rd_req;
            if (r_state == S_RDLOAD && r_rd_req_d) begin
                r_tx <= rd_data;
            end

            if (r_state != S_IDLE && r_state != S_WAITCS && w_cs_rise) begin
                frame_err <= 1'b1;
                MISO      <= 1'b0;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        MISO <= 1'b0;
                        if (w_cs_fall) begin
                            r_cnt   <= '0;
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            r_shift <= w_shift_next;
                            if (r_cnt == c_CMD_LAST) begin
                                cmd_out <= w_shift_next[CMD_W-1:0];
                                r_cnt   <= '0;
                                r_state <= S_ADDR;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_shift <= w_shift_next;
                            if (r_cnt == c_ADDR_LAST) begin
                                addr_out <= w_shift_next[ADDR_W-1:0];
                                r_cnt    <= '0;
                                if (cmd_out == CMD_READ) begin
                                    rd_req  <= 1'b1;
                                    r_state <= S_RDLOAD;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                    end
                    S_RDLOAD: begin
                        if (w_fall) begin
                            MISO    <= w_tx_src[DATA_W-1];
                            r_state <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        if (w_fall) begin
                            r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                            MISO <= r_tx[DATA_W-2];
                        end
                        if (w_rise) begin
                            if (r_cnt == c_DATA_LAST) begin
                                frame_valid <= 1'b1;
                                MISO        <= 1'b0;
                                r_state     <= S_WAITCS;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            r_shift <= w_shift_next;
                            if (r_cnt == c_DATA_LAST) begin
                                wr_data     <= w_shift_next[DATA_W-1:0];
                                frame_valid <= 1'b1;
                                r_state     <= S_WAITCS;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                    end
                    S_WAITCS: begin
                        MISO <= 1'b0;
                        if (w_cs) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        MISO    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_frame
// Brief    : Directed self-checking bench for spi_slave_frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic        CS;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [31:0] rd_data;
    logic [7:0]  cmd_out;
    logic [23:0] addr_out;
    logic [31:0] wr_data;
    logic        rd_req;
    logic        frame_valid;
    logic        frame_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor state, written only by the monitor process
    int          cyc      = 0;
    int          n_fv     = 0;
    int          n_rr     = 0;
    int          n_fe     = 0;
    int          n_miso   = 0;
    int          n_bad    = 0;
    int          fv_cyc   = 0;
    int          rr_cyc   = 0;
    logic [23:0] rr_addr  = '0;
    logic        p_fv     = 1'b0;
    logic        p_rr     = 1'b0;
    logic        p_fe     = 1'b0;
    logic [31:0] rd_word  = '0;

    spi_slave_frame dut (
        .clk         (clk),
        .rst         (rst),
        .CS          (CS),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .rd_data     (rd_data),
        .cmd_out     (cmd_out),
        .addr_out    (addr_out),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory side with one cycle of latency; any other cycle shows junk
    always @(posedge clk) rd_data <= rd_req ? rd_word : 32'h5A5A_5A5A;

    always @(negedge clk) begin
        if (frame_valid) begin n_fv = n_fv + 1; fv_cyc = cyc; end
        if (rd_req) begin n_rr = n_rr + 1; rr_cyc = cyc; rr_addr = addr_out; end
        if (frame_err) n_fe = n_fe + 1;
        if (MISO === 1'b1) n_miso = n_miso + 1;
        if ((int'(frame_valid) + int'(rd_req) + int'(frame_err)) > 1) n_bad = n_bad + 1;
        if ((frame_valid && p_fv) || (rd_req && p_rr) || (frame_err && p_fe)) n_bad = n_bad + 1;
        p_fv = frame_valid;
        p_rr = rd_req;
        p_fe = frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Mode-0 master: MOSI changes while SCLK low, MISO captured just before each rise
    task automatic spi_xfer(input logic [63:0] bits, input int npulse, input int half,
                            input bit raise_cs, output logic [31:0] miso_cap,
                            output int last_rise);
        miso_cap  = '0;
        last_rise = 0;
        @(negedge clk);
        CS = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < npulse; i++) begin
            MOSI = (i < 64) ? bits[63-i] : 1'b0;
            repeat (half) @(negedge clk);
            miso_cap = {miso_cap[30:0], MISO};
            if (i == 63) last_rise = cyc;
            SCLK = 1'b1;
            repeat (half) @(negedge clk);
            SCLK = 1'b0;
        end
        if (raise_cs) begin
            repeat (half) @(negedge clk);
            CS   = 1'b1;
            MOSI = 1'b0;
            repeat (4 * half) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({cmd_out, addr_out, wr_data} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h/%h/%h expected 0/0/0", cmd_out, addr_out, wr_data);
        end
        n_cmp++;
        if ({MISO, rd_req, frame_valid, frame_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 0000", {MISO, rd_req, frame_valid, frame_err});
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [31:0] cap;
        int lr, fv0, rr0, fe0, m0;
        fv0 = n_fv; rr0 = n_rr; fe0 = n_fe; m0 = n_miso;
        spi_xfer({8'h69, 24'h2AAAAC, 32'h8B957B65}, 64, 2, 1'b1, cap, lr);
        n_cmp++;
        if (n_fv - fv0 !== 1) begin n_fail++; $display("FAIL write_fv_count: got %0d expected 1", n_fv - fv0); end
        n_cmp++;
        if (cmd_out !== 8'h69) begin n_fail++; $display("FAIL write_cmd: got %h expected 69", cmd_out); end
        n_cmp++;
        if (addr_out !== 24'h2AAAAC) begin n_fail++; $display("FAIL write_addr: got %h expected 2aaaac", addr_out); end
        n_cmp++;
        if (wr_data !== 32'h8B957B65) begin n_fail++; $display("FAIL write_data: got %h expected 8b957b65", wr_data); end
        n_cmp++;
        if ((n_rr - rr0) + (n_fe - fe0) !== 0) begin
            n_fail++; $display("FAIL write_no_rdreq_err: got %0d expected 0", (n_rr - rr0) + (n_fe - fe0));
        end
        n_cmp++;
        if (n_miso - m0 !== 0) begin n_fail++; $display("FAIL write_miso_low: got %0d high cycles expected 0", n_miso - m0); end
        n_cmp++;
        if (fv_cyc - lr !== 3) begin n_fail++; $display("FAIL write_latency: got %0d expected 3", fv_cyc - lr); end
    endtask

    task automatic test_read();
        logic [31:0] cap;
        int lr, fv0, rr0;
        fv0 = n_fv; rr0 = n_rr;
        rd_word = 32'hDEADBEEF;
        spi_xfer({8'h03, 24'h000010, 32'h0}, 64, 4, 1'b1, cap, lr);
        n_cmp++;
        if (n_rr - rr0 !== 1) begin n_fail++; $display("FAIL read_rdreq_count: got %0d expected 1", n_rr - rr0); end
        n_cmp++;
        if (rr_addr !== 24'h000010) begin n_fail++; $display("FAIL read_rdreq_addr: got %h expected 000010", rr_addr); end
        n_cmp++;
        if (cap !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_miso_word: got %h expected deadbeef", cap); end
        n_cmp++;
        if (n_fv - fv0 !== 1 || fv_cyc <= rr_cyc) begin
            n_fail++; $display("FAIL read_fv: got count %0d order %0d expected 1 after rd_req", n_fv - fv0, fv_cyc - rr_cyc);
        end
        n_cmp++;
        if (wr_data !== 32'h8B957B65) begin n_fail++; $display("FAIL read_wrdata_kept: got %h expected 8b957b65", wr_data); end
        n_cmp++;
        if (MISO !== 1'b0) begin n_fail++; $display("FAIL read_miso_idle: got %b expected 0", MISO); end
    endtask

    task automatic test_abort();
        logic [31:0] cap;
        int lr, fv0, fe0;
        fv0 = n_fv; fe0 = n_fe;
        spi_xfer({8'h69, 24'h2AAAAC, 32'h8B957B65}, 20, 2, 1'b1, cap, lr);
        n_cmp++;
        if (n_fe - fe0 !== 1 || n_fv - fv0 !== 0) begin
            n_fail++; $display("FAIL abort_pulses: got err %0d valid %0d expected 1 0", n_fe - fe0, n_fv - fv0);
        end
        n_cmp++;
        if (cmd_out !== 8'h69 || addr_out !== 24'h000010) begin
            n_fail++; $display("FAIL abort_kept: got %h/%h expected 69/000010", cmd_out, addr_out);
        end
        spi_xfer({8'h69, 24'h000ABC, 32'h12345678}, 64, 2, 1'b1, cap, lr);
        n_cmp++;
        if (wr_data !== 32'h12345678 || addr_out !== 24'h000ABC || n_fv - fv0 !== 1) begin
            n_fail++; $display("FAIL abort_next_frame: got %h/%h/%0d expected 12345678/000abc/1",
                               wr_data, addr_out, n_fv - fv0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] cap;
        int lr, fv0;
        spi_xfer({8'h03, 24'h2AAAAC, 32'h8B957B65}, 20, 2, 1'b0, cap, lr);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_out, addr_out, wr_data, MISO, rd_req, frame_valid, frame_err} !== 68'h0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %h/%h/%h/%b expected all 0",
                               cmd_out, addr_out, wr_data, {MISO, rd_req, frame_valid, frame_err});
        end
        @(negedge clk);
        CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        fv0 = n_fv;
        spi_xfer({8'h69, 24'h2AAAAC, 32'h8B957B65}, 64, 2, 1'b1, cap, lr);
        n_cmp++;
        if ({cmd_out, addr_out, wr_data} !== {8'h69, 24'h2AAAAC, 32'h8B957B65} || n_fv - fv0 !== 1) begin
            n_fail++; $display("FAIL reset_mid_recover: got %h/%h/%h/%0d expected 69/2aaaac/8b957b65/1",
                               cmd_out, addr_out, wr_data, n_fv - fv0);
        end
    endtask

    task automatic test_overclock();
        logic [31:0] cap;
        int lr, fv0, fe0;
        fv0 = n_fv; fe0 = n_fe;
        spi_xfer({8'h69, 24'h2AAAAC, 32'h8B957B65}, 70, 2, 1'b1, cap, lr);
        n_cmp++;
        if (n_fv - fv0 !== 1 || n_fe - fe0 !== 0) begin
            n_fail++; $display("FAIL overclock_pulses: got valid %0d err %0d expected 1 0", n_fv - fv0, n_fe - fe0);
        end
        n_cmp++;
        if (wr_data !== 32'h8B957B65) begin n_fail++; $display("FAIL overclock_data: got %h expected 8b957b65", wr_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cap;
        int lr, fv0;
        fv0 = n_fv;
        spi_xfer({8'h69, 24'h000100, 32'h00000001}, 64, 2, 1'b1, cap, lr);
        n_cmp++;
        if (wr_data !== 32'h00000001) begin n_fail++; $display("FAIL b2b_first: got %h expected 00000001", wr_data); end
        spi_xfer({8'h69, 24'h000104, 32'hFFFFFFFF}, 64, 2, 1'b1, cap, lr);
        n_cmp++;
        if (wr_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_second: got %h expected ffffffff", wr_data); end
        n_cmp++;
        if (n_fv - fv0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", n_fv - fv0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_mid();
        test_overclock();
        test_back_to_back();
        n_cmp++;
        if (n_bad !== 0) begin n_fail++; $display("FAIL pulse_shape: got %0d overlapping/wide pulses expected 0", n_bad); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
- SPI mode-0 slave that consumes the serial frame produced by SPI_Master (CS, SCLK, MOSI) and returns MISO.
- Deserialises one frame of command (8), address (24) and data (32), MSB first, into parallel registers, and raises a one-cycle valid pulse.
- For the read command it requests a data word from the local register/memory side and shifts that word out on MISO during the data phase.
- Oversamples all SPI pins in the system clock domain; no logic is clocked by SCLK.

Parameters:
- CMD_W, 8, command field width in bits.
- ADDR_W, 24, address field width in bits.
- DATA_W, 32, data field width in bits.
- CMD_READ, 8'h03, command code that selects read (MISO drive) instead of write.
- SYNC_STAGES, 2, flip-flop stages on CS, SCLK and MOSI (minimum 2).

Ports:
- clk  in  1  system clock; SCLK period must be at least 4 clk periods.
- rst  in  1  asynchronous, active-low reset.
- CS  in  1  chip select from master, active low.
- SCLK  in  1  serial clock from master, idle low.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- rd_data  in  DATA_W  word to return; sampled on the cycle after rd_req.
- cmd_out  out  CMD_W  captured command.
- addr_out  out  ADDR_W  captured address.
- wr_data  out  DATA_W  captured data (write frames).
- rd_req  out  1  one-cycle pulse; addr_out is valid and the command is CMD_READ.
- frame_valid  out  1  one-cycle pulse; a complete frame has been received.
- frame_err  out  1  one-cycle pulse; CS deasserted before the frame completed.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE and all sync flops are set to the idle levels (CS=1, SCLK=0, MOSI=0).
  - Bit counter, shift register, cmd_out, addr_out and wr_data clear to 0.
  - MISO, rd_req, frame_valid and frame_err are 0.
- Synchronisation and edge detection:
  - CS, SCLK and MOSI each pass through SYNC_STAGES flops.
  - Rise is asserted when the synced SCLK is 1 and its previous value was 0; fall is the opposite.
  - MOSI is sampled only on a rise cycle; MISO is updated only on a fall cycle.
- FSM, 7-bit bit counter:
  - IDLE: MISO=0. Synced CS falling moves to CMD and clears the counter.
  - CMD: each rise shifts MOSI into the LSB of the shift register. On the CMD_W-th bit, load cmd_out and go to ADDR.
  - ADDR: on the ADDR_W-th address bit, load addr_out.
    - If cmd_out==CMD_READ: pulse rd_req and go to RDLOAD.
    - Otherwise go to WDATA.
  - RDLOAD: latch rd_data into the TX register on the cycle after rd_req. The next fall drives TX[DATA_W-1] onto MISO, then go to RDATA.
  - RDATA: each following fall shifts TX left and drives the new MSB. Rises count bits; on the DATA_W-th rise pulse frame_valid and go to WAIT_CS.
  - WDATA: on the DATA_W-th rise, load wr_data, pulse frame_valid and go to WAIT_CS.
  - WAIT_CS: ignore SCLK, MISO=0. Synced CS high moves to IDLE.
- Abort: synced CS rising in CMD, ADDR, RDLOAD, RDATA or WDATA:
  - pulse frame_err and go to IDLE;
  - cmd_out, addr_out and wr_data keep their last loaded values; no frame_valid.
- Extra SCLK edges after the full frame, while CS is still low, are ignored (WAIT_CS).
- CS falling and a rise detected in the same cycle: the edge is dropped. The master guarantees at least half an SCLK period of setup.
- Latency: frame_valid asserts SYNC_STAGES+1 clk cycles after the final SCLK rising edge at the pins.
- A write frame never modifies the TX register; a read frame leaves wr_data unchanged.
- Pulses rd_req, frame_valid and frame_err are exactly one clk cycle wide and mutually exclusive.

Test Plan:
- Write frame: cmd 8'h69, addr 24'h2AAAAC, data 32'h8B957B65, SCLK = clk/4 → one frame_valid pulse with cmd_out=69, addr_out=2AAAAC, wr_data=8B957B65; rd_req never asserts; MISO stays 0.
- Read frame: cmd 8'h03, addr 24'h000010, rd_data=32'hDEADBEEF → rd_req pulses with addr_out=000010; master-side capture of MISO on 32 rising edges reads DEADBEEF; then frame_valid pulses.
- Abort: CS raised after 20 bits of a write frame → frame_err pulses once, no frame_valid, FSM in IDLE; the next full frame (cmd 8'h69, data 32'h12345678) is received correctly.
- Reset mid-frame: rst=0 during the address phase → all outputs 0 immediately; after release, frame cmd 8'h69, addr 24'h2AAAAC, data 32'h8B957B65 decodes correctly.
- Overclocking: 70 SCLK pulses within one CS low window, write frame 8'h69/24'h2AAAAC/32'h8B957B65 → single frame_valid with the first 64 bits only; wr_data=8B957B65.
- Back-to-back: two write frames separated by 2 SCLK periods of CS high, data 32'h00000001 then 32'hFFFFFFFF → two frame_valid pulses, wr_data 00000001 then FFFFFFFF.
